// File: rtl/cv32e41p_div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the enable/ready/ex_ready handshake with the multiplier.
// Optional feature macro: CV32E41P_DIV_EARLY_EXIT_EN (skips leading-zero
// iterations of the dividend; results are unchanged).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable_i       division request (accepted only in IDLE)
//   operator_i     00 DIVU, 01 DIV, 10 REMU, 11 REM
//   op_a_i/op_b_i  dividend / divisor, sampled on the accept cycle
//   result_o       quotient or remainder, valid while ready_o=1 after a request
//   ready_o        unit free / result valid
//   multicycle_o   high while iterating
//   ex_ready_i     EX stage consumes the result
module cv32e41p_div_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [1:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ready_o,
  output logic                  multicycle_o,
  input  logic                  ex_ready_i
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = 5;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     abs_b_q;
  logic             want_rem;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;
  logic             ovf;
  logic [W:0]       trial;
  logic [W-1:0]     rem_shift;
  logic [CNT_W-1:0] start_count;
  logic [W-1:0]     start_quo;
  logic             early_zero;

  // Operand conditioning for the accept cycle
  always_comb begin
    sgn   = operator_i[0];
    abs_a = (sgn && op_a_i[W-1]) ? W'(-op_a_i) : op_a_i;
    abs_b = (sgn && op_b_i[W-1]) ? W'(-op_b_i) : op_b_i;
    ovf   = sgn && (op_a_i == MIN_NEG) && (op_b_i == {W{1'b1}});
  end

`ifdef CV32E41P_DIV_EARLY_EXIT_EN
  logic [5:0] lz;

  // Leading-zero count of |A|; the highest set bit wins
  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (abs_a[i]) lz = 6'(31 - i);
    end
  end

  always_comb begin
    early_zero  = (lz == 6'd32);
    start_count = CNT_W'(6'd31 - lz);
    start_quo   = abs_a << lz;
  end
`else
  always_comb begin
    early_zero  = 1'b0;
    start_count = CNT_W'(31);
    start_quo   = abs_a;
  end
`endif

  // One restoring step: quo_q MSB shifts into the partial remainder
  always_comb begin
    trial     = {rem_q, quo_q[W-1]} - {1'b0, abs_b_q};
    rem_shift = {rem_q[W-2:0], quo_q[W-1]};
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      abs_b_q  <= '0;
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) begin
            want_rem <= operator_i[1];
            abs_b_q  <= abs_b;
            neg_q    <= sgn && (op_a_i[W-1] ^ op_b_i[W-1]) && (op_b_i != '0);
            neg_r    <= sgn && op_a_i[W-1];
            if (op_b_i == '0) begin
              // Special results are stored final, so sign fix-up is off
              quo_q <= {W{1'b1}};
              rem_q <= op_a_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else if (ovf) begin
              quo_q <= MIN_NEG;
              rem_q <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else if (early_zero) begin
              quo_q <= '0;
              rem_q <= '0;
              state <= FINISH;
            end else begin
              quo_q <= start_quo;
              rem_q <= '0;
              count <= start_count;
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (!trial[W]) begin
            rem_q <= trial[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift;
            quo_q <= {quo_q[W-2:0], 1'b0};
          end
          if (count == '0) state <= FINISH;
          else             count <= count - 1'b1;
        end
        FINISH: begin
          if (ex_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; ready drops on the accept cycle
  always_comb begin
    result_o     = '0;
    ready_o      = 1'b0;
    multicycle_o = 1'b0;
    case (state)
      IDLE:    ready_o = !enable_i;
      DIVIDE:  multicycle_o = 1'b1;
      FINISH: begin
        ready_o  = 1'b1;
        result_o = want_rem ? (neg_r ? W'(-rem_q) : rem_q)
                            : (neg_q ? W'(-quo_q) : quo_q);
      end
      default: ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cv32e41p_div_seq.sv
// Self-checking bench for cv32e41p_div_seq: scoreboard of expected results
// from an independent RV32M reference model, one task per scenario.
module tb_cv32e41p_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [1:0]  operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        multicycle_o;
  logic        ex_ready_i;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  localparam logic [1:0] DIVU = 2'b00, DIV = 2'b01, REMU = 2'b10, REM = 2'b11;

  cv32e41p_div_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .operator_i(operator_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .result_o(result_o), .ready_o(ready_o),
    .multicycle_o(multicycle_o), .ex_ready_i(ex_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa = a; sbv = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Number of ready-low cycles from accept until the result is presented
  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int lz;
    if (b == 32'd0) return 1;
    if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef CV32E41P_DIV_EARLY_EXIT_EN
    mag = (op[0] && a[31]) ? 32'(-a) : a;
    lz = 32;
    for (int i = 31; i >= 0; i--) if (mag[i]) begin lz = 31 - i; break; end
    if (lz == 32) return 1;
    return 1 + (32 - lz);
`else
    mag = a;
    lz = 0;
    return 33;
`endif
  endfunction

  // Drive a request at a negedge, push expected result, wait for ready
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit timeout);
    enable_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
    enable_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; operator_i = 2'($urandom);
    lat = 1;
    while (ready_o !== 1'b1 && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    timeout = (lat >= 200);
  endtask

  task automatic release_result();
    ex_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ex_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b0; operator_i = '0; op_a_i = '0; op_b_i = '0; ex_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b multi=%b result=%h, required 1 0 00000000", ready_o, multicycle_o, result_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat; bit to; logic [31:0] exp;
    enable_i = 1'b1; operator_i = DIVU; op_a_i = 32'd100; op_b_i = 32'd7;
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++; $display("FAIL accept_ready: got %b required 0", ready_o);
    end
    sb.push_back(model(DIVU, 32'd100, 32'd7));
    @(posedge clk); @(negedge clk);
    enable_i = 1'b0;
    vectors++;
    if (multicycle_o !== 1'b1) begin
      miscompares++; $display("FAIL divide_multicycle: got %b required 1", multicycle_o);
    end
    lat = 1;
    while (ready_o !== 1'b1 && lat < 200) begin lat++; @(negedge clk); end
    to = (lat >= 200);
    exp = sb.pop_front();
    vectors++;
    if (to || lat != exp_latency(DIVU, 32'd100, 32'd7)) begin
      miscompares++; $display("FAIL divu_latency: got %0d required %0d", lat, exp_latency(DIVU, 32'd100, 32'd7));
    end
    vectors++;
    if (result_o !== exp || multicycle_o !== 1'b0) begin
      miscompares++; $display("FAIL divu_100_7: got %h multi=%b required %h multi=0", result_o, multicycle_o, exp);
    end
    release_result();
    vectors++;
    if (ready_o !== 1'b1 || result_o !== 32'd0) begin
      miscompares++; $display("FAIL return_idle: ready=%b result=%h required 1 00000000", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int lat; bit to; logic [31:0] exp;
    logic [1:0] ops [2] = '{REM, DIV};
    logic [31:0] req [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], 32'hFFFF_FFF9, 32'd2, lat, to);
      exp = sb.pop_front();
      vectors++;
      if (to || result_o !== req[i] || exp !== req[i]) begin
        miscompares++; $display("FAIL signed_m7_2 op=%0d: got %h required %h", ops[i], result_o, req[i]);
      end
      release_result();
    end
  endtask

  task automatic test_special();
    int lat; bit to; logic [31:0] exp;
    logic [1:0]  ops [4] = '{DIV, REM, DIVU, REMU};
    logic [31:0] as  [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] req [4] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, to);
      exp = sb.pop_front();
      vectors++;
      if (to || lat != 1 || result_o !== req[i] || exp !== req[i]) begin
        miscompares++; $display("FAIL special_%0d: got %h lat %0d required %h lat 1", i, result_o, lat, req[i]);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    int lat; bit to; logic [31:0] exp;
    run_op(DIV, 32'hFFFF_FF9C, 32'd7, lat, to);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      op_a_i = $urandom; op_b_i = $urandom; operator_i = 2'($urandom);
      #1;
      vectors++;
      if (to || result_o !== exp || ready_o !== 1'b1) begin
        miscompares++; $display("FAIL hold_%0d: got %h ready=%b required %h ready=1", i, result_o, ready_o, exp);
      end
      @(negedge clk);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat; bit to; logic [31:0] exp;
    enable_i = 1'b1; operator_i = DIVU; op_a_i = 32'd1000; op_b_i = 32'd3;
    @(posedge clk); @(negedge clk);
    enable_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid: ready=%b multi=%b result=%h required 1 0 00000000", ready_o, multicycle_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(DIVU, 32'd9, 32'd3, lat, to);
    exp = sb.pop_front();
    vectors++;
    if (to || result_o !== 32'd3 || exp !== 32'd3) begin
      miscompares++; $display("FAIL after_reset_divu_9_3: got %h required 00000003", result_o);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; bit to; logic [31:0] exp;
    run_op(REMU, 32'd1234567, 32'd1000, lat, to);
    exp = sb.pop_front();
    vectors++;
    if (to || result_o !== exp) begin
      miscompares++; $display("FAIL b2b_first: got %h required %h", result_o, exp);
    end
    // Request presented in FINISH together with ex_ready: not accepted there
    enable_i = 1'b1; operator_i = DIVU; op_a_i = 32'd77; op_b_i = 32'd11; ex_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    ex_ready_i = 1'b0;
    vectors++;
    if (ready_o !== 1'b0 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++; $display("FAIL b2b_reaccept: ready=%b multi=%b result=%h required 0 0 00000000", ready_o, multicycle_o, result_o);
    end
    run_op(DIVU, 32'd77, 32'd11, lat, to);
    exp = sb.pop_front();
    vectors++;
    if (to || result_o !== exp || lat != exp_latency(DIVU, 32'd77, 32'd11)) begin
      miscompares++; $display("FAIL b2b_second: got %h lat %0d required %h lat %0d", result_o, lat, exp, exp_latency(DIVU, 32'd77, 32'd11));
    end
    release_result();
  endtask

  task automatic test_random();
    int lat; bit to; logic [31:0] exp, a, b; logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) a = a >> $urandom_range(0, 31);
      if (i % 10 == 7) b = 32'hFFFF_FFFF;
      run_op(op, a, b, lat, to);
      exp = sb.pop_front();
      vectors++;
      if (to || result_o !== exp || lat != exp_latency(op, a, b)) begin
        miscompares++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat %0d required %h lat %0d", i, op, a, b, result_o, lat, exp, exp_latency(op, a, b));
      end
      release_result();
    end
  endtask

`ifdef CV32E41P_DIV_EARLY_EXIT_EN
  task automatic test_early_exit();
    int lat; bit to; logic [31:0] exp;
    run_op(DIVU, 32'd1, 32'd1, lat, to);
    exp = sb.pop_front();
    vectors++;
    if (to || lat != 2 || result_o !== 32'd1 || exp !== 32'd1) begin
      miscompares++; $display("FAIL early_1_1: got %h lat %0d required 00000001 lat 2", result_o, lat);
    end
    release_result();
    run_op(DIVU, 32'd0, 32'd3, lat, to);
    exp = sb.pop_front();
    vectors++;
    if (to || lat != 1 || result_o !== 32'd0 || exp !== 32'd0) begin
      miscompares++; $display("FAIL early_0_3: got %h lat %0d required 00000000 lat 1", result_o, lat);
    end
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_special();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef CV32E41P_DIV_EARLY_EXIT_EN
    test_early_exit();
`endif
    test_random();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
